sd_sector_xfer: RTL

//  SPI-mode single-sector transfer engine downstream of the SD sector address controller.

---
 rtl/sd_pkg.sv | 47 ++++
 rtl/sd_spi_byte.sv | 102 ++++++++++
 rtl/sd_sector_xfer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD sector transfer engine.
// Command framing helper lives here so the top stays focused on sequencing.
package sd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_TOK,
    S_RDAT,
    S_RCRC,
    S_WGAP,
    S_WTOK,
    S_WDAT,
    S_WCRC,
    S_DRSP,
    S_BSY,
    S_TAIL,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] CMD17     = 8'h51;
  localparam logic [7:0] CMD24     = 8'h58;
  localparam logic [7:0] TOKEN     = 8'hFE;
  localparam logic [7:0] FILL      = 8'hFF;
  localparam logic [4:0] DRESP_OK  = 5'h05;
  localparam int         SECTOR_BYTES = 512;

  function automatic logic [7:0] cmd_byte(
    input logic        wr,
    input logic [31:0] addr,
    input logic [2:0]  idx
  );
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = wr ? CMD24 : CMD17;
      3'd1:    b = addr[31:24];
      3'd2:    b = addr[23:16];
      3'd3:    b = addr[15:8];
      3'd4:    b = addr[7:0];
      default: b = FILL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter: SCLK divider plus TX/RX shift registers.
// The last high phase is cut to one clk so SCLK is back low when done pulses.
module sd_spi_byte #(
  parameter int CLKDIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] tx_i,
  input  logic       miso_i,
  output logic       done_o,
  output logic [7:0] rx_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic          act_q,  act_d;
  logic          last_q, last_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
  logic [2:0]    bit_q,  bit_d;
  logic [DW-1:0] div_q,  div_d;
  logic [7:0]    tx_q,   tx_d;
  logic [7:0]    rx_q,   rx_d;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= 1'b0;
      last_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b1;
      done_q <= 1'b0;
      bit_q  <= '0;
      div_q  <= '0;
      tx_q   <= '1;
      rx_q   <= '0;
    end else begin
      act_q  <= act_d;
      last_q <= last_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      bit_q  <= bit_d;
      div_q  <= div_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  always_comb begin
    act_d  = act_q;
    last_d = last_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    bit_d  = bit_q;
    div_d  = div_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    if (!act_q) begin
      sclk_d = 1'b0;
      mosi_d = 1'b1;
      if (start_i) begin
        act_d  = 1'b1;
        last_d = 1'b0;
        tx_d   = tx_i;
        mosi_d = tx_i[7];
        bit_d  = '0;
        div_d  = '0;
      end
    end else if (last_q) begin
      act_d  = 1'b0;
      last_d = 1'b0;
      sclk_d = 1'b0;
      mosi_d = 1'b1;
      done_d = 1'b1;
    end else if (div_q == DW'(CLKDIV - 1)) begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
        if (bit_q == 3'd7) last_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        tx_d   = {tx_q[6:0], 1'b1};
        mosi_d = tx_q[6];
        bit_d  = bit_q + 3'd1;
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  assign done_o = done_q;
  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/sd_sector_xfer.sv
// Single-sector CMD17/CMD24 transfer engine over SPI-mode SD.
// One byte is in flight at a time; each state reacts to the byte engine's done.
module sd_sector_xfer
  import sd_pkg::*;
#(
  parameter int CLKDIV      = 2,
  parameter int R1_TIMEOUT  = 8,
  parameter int TOK_TIMEOUT = 4096,
  parameter int BSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rden,
  input  logic        wren,
  input  logic        sdhc,
  input  logic [31:0] DADDR,
  output logic [7:0]  RDATA,
  output logic        rdvalid,
  input  logic [7:0]  WDATA,
  output logic        wdreq,
  output logic        busy,
  output logic        tcvdptdone,
  output logic        sd_err,
  output logic        sd_cs,
  output logic        sd_sclk,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic        infl_q, infl_d;
  logic        wdreq_q, wdreq_d;
  logic        rdv_q, rdv_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cs_q, cs_d;

  logic       start;
  logic [7:0] tx;
  logic       bdone;
  logic [7:0] rx;
  logic       xfer;

  sd_spi_byte #(.CLKDIV(CLKDIV)) u_byte (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .tx_i    (tx),
    .miso_i  (sd_miso),
    .done_o  (bdone),
    .rx_o    (rx),
    .sclk_o  (sd_sclk),
    .mosi_o  (sd_mosi)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      infl_q  <= 1'b0;
      wdreq_q <= 1'b0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      infl_q  <= infl_d;
      wdreq_q <= wdreq_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    tx      = FILL;
    unique case (state_q)
      S_IDLE: begin
        if (rden || wren) begin
          wr_d    = !rden;
          addr_d  = sdhc ? DADDR : {DADDR[22:0], 9'b0};
          err_d   = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        tx = cmd_byte(wr_q, addr_q, cnt_q[2:0]);
        if (bdone) begin
          if (cnt_q == 10'd5) state_d = S_R1;
          else cnt_d = cnt_q + 10'd1;
        end
      end
      S_R1: begin
        if (bdone) begin
          if (!rx[7])
            state_d = (rx != 8'h00) ? S_ERR :
                      wr_q ? S_WGAP : S_TOK;
          else if (tmo_q == 16'(R1_TIMEOUT - 1))
            state_d = S_ERR;
          else
            tmo_d = tmo_q + 16'd1;
        end
      end
      S_TOK: begin
        if (bdone) begin
          if (rx == TOKEN) state_d = S_RDAT;
          else if (rx[7:4] == 4'h0) state_d = S_ERR;
          else if (tmo_q == 16'(TOK_TIMEOUT - 1)) state_d = S_ERR;
          else tmo_d = tmo_q + 16'd1;
        end
      end
      S_RDAT: begin
        if (bdone) begin
          rdv_d   = 1'b1;
          rdata_d = rx;
          if (cnt_q == 10'(SECTOR_BYTES - 1)) state_d = S_RCRC;
          else cnt_d = cnt_q + 10'd1;
        end
      end
      S_RCRC: begin
        if (bdone) begin
          if (cnt_q == 10'd1) state_d = S_TAIL;
          else cnt_d = cnt_q + 10'd1;
        end
      end
      S_WGAP: if (bdone) state_d = S_WTOK;
      S_WTOK: begin
        tx = TOKEN;
        if (bdone) state_d = S_WDAT;
      end
      S_WDAT: begin
        tx = WDATA;
        if (bdone) begin
          if (cnt_q == 10'(SECTOR_BYTES - 1)) state_d = S_WCRC;
          else cnt_d = cnt_q + 10'd1;
        end
      end
      S_WCRC: begin
        if (bdone) begin
          if (cnt_q == 10'd1) state_d = S_DRSP;
          else cnt_d = cnt_q + 10'd1;
        end
      end
      S_DRSP: begin
        if (bdone)
          state_d = (rx[4:0] == DRESP_OK) ? S_BSY : S_ERR;
      end
      S_BSY: begin
        if (bdone) begin
          if (rx == FILL) state_d = S_TAIL;
          else if (tmo_q == 16'(BSY_TIMEOUT - 1)) state_d = S_ERR;
          else tmo_d = tmo_q + 16'd1;
        end
      end
      // The sticky error doubles as the "abort path" marker here
      S_TAIL: if (bdone) state_d = err_q ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_TAIL;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end

    xfer    = !(state_q inside {S_IDLE, S_DONE, S_ERR});
    wdreq_d = (state_q == S_WDAT) && !infl_q && !wdreq_q;
    start   = xfer && !infl_q &&
              ((state_q != S_WDAT) || wdreq_q);
    infl_d  = start || (infl_q && !bdone);
    cs_d    = state_d inside {S_IDLE, S_TAIL, S_DONE, S_ERR};
  end

  assign RDATA      = rdata_q;
  assign rdvalid    = rdv_q;
  assign wdreq      = wdreq_q;
  assign busy       = (state_q != S_IDLE);
  assign tcvdptdone = (state_q == S_DONE);
  assign sd_err     = err_q;
  assign sd_cs      = cs_q;

endmodule
